mem_responder: RTL

Memory-side responder for the datapath's MAR/MDR memory interface. Accepts read and write requests raised by the control sequencer, addresses a 512×32 word store with the MAR value, and returns read data on `m_data_in` for capture into the MDR. A programmable wait-state counter models slow memory, and a one-cycle `mem_ready` pulse tells the control unit when to advance.

---
 rtl/cpu_mem_pkg.sv | 26 ++
 rtl/mem_responder_if.sv | 28 ++
 rtl/ram_sp_sync.sv | 36 +++
 rtl/mem_responder.sv | 136 +++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and default sizes for the MAR/MDR memory responder.
package cpu_mem_pkg;

    localparam int unsigned DEF_ADDR_W = 9;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned CNT_W      = 4;

    // Word count of a store addressed by an aw-bit word address
    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'(1) << aw;
    endfunction

    localparam int unsigned MEM_DEPTH = depth_of(DEF_ADDR_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        DIR_READ  = 1'b0,
        DIR_WRITE = 1'b1
    } dir_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the control sequencer and the memory responder.
interface mem_responder_if
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) ();

    logic              read;
    logic              write;
    logic [ADDR_W-1:0] mar_addr;
    logic [DATA_W-1:0] mdr_data;
    logic [DATA_W-1:0] m_data_in;
    logic              mem_ready;
    logic              busy;
    logic              err;

    modport master (
        output read, write, mar_addr, mdr_data,
        input  m_data_in, mem_ready, busy, err
    );

    modport slave (
        input  read, write, mar_addr, mdr_data,
        output m_data_in, mem_ready, busy, err
    );

endinterface

// File: rtl/ram_sp_sync.sv
// Single-port synchronous RAM with a registered read port that holds between reads.
module ram_sp_sync
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array: written only on an enabled write, never reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register: updates only on a completed read, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one armed read/write, inserts wait states,
// performs the access and pulses mem_ready for one cycle.
module mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              clr,
    mem_responder_if.slave    bus
);

    localparam int unsigned     DEPTH   = depth_of(ADDR_W);
    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);
    localparam bit              NO_WAIT = (WAIT_CYCLES == 0);

    state_e            state;
    logic              armed;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    dir_e              dir_q;
    logic              mem_ready_q;
    logic              busy_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata;

    logic              one_req_c;
    logic              both_req_c;
    logic              accept_c;
    logic              access_c;
    dir_e              acc_dir_c;
    logic [ADDR_W-1:0] ram_addr_c;
    logic [DATA_W-1:0] ram_wdata_c;
    logic              ram_we_c;
    logic              ram_re_c;

    // Request decode and RAM port steering; with no wait states the access
    // happens on the accepting edge, so the live bus values are used then
    always_comb begin
        one_req_c   = bus.read ^ bus.write;
        both_req_c  = bus.read & bus.write;
        accept_c    = (state == ST_IDLE) && armed && one_req_c;
        access_c    = (accept_c && NO_WAIT) ||
                      ((state == ST_WAIT) && (cnt == CNT_W'(1)));
        acc_dir_c   = dir_q;
        ram_addr_c  = addr_q;
        ram_wdata_c = data_q;
        if (state == ST_IDLE) begin
            acc_dir_c   = bus.write ? DIR_WRITE : DIR_READ;
            ram_addr_c  = bus.mar_addr;
            ram_wdata_c = bus.mdr_data;
        end
        ram_we_c    = access_c && (acc_dir_c == DIR_WRITE) && clr;
        ram_re_c    = access_c && (acc_dir_c == DIR_READ) && clr;
    end

    // Responder FSM with arming, wait-state counting and registered status outputs
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state       <= ST_IDLE;
            armed       <= 1'b1;
            cnt         <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            dir_q       <= DIR_READ;
            mem_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_ready_q <= 1'b0;
            err_q       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (armed && both_req_c) begin
                        err_q <= 1'b1;
                        armed <= 1'b0;
                    end else if (accept_c) begin
                        addr_q <= bus.mar_addr;
                        data_q <= bus.mdr_data;
                        dir_q  <= bus.write ? DIR_WRITE : DIR_READ;
                        cnt    <= WAIT_LD;
                        armed  <= 1'b0;
                        busy_q <= 1'b1;
                        if (NO_WAIT) begin
                            state       <= ST_RESP;
                            mem_ready_q <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end else if (!bus.read && !bus.write) begin
                        armed <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state       <= ST_RESP;
                        mem_ready_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Word store; its read register is the m_data_in output
    ram_sp_sync #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk    (clk),
        .rst_n  (clr),
        .we     (ram_we_c),
        .re     (ram_re_c),
        .addr   (ram_addr_c),
        .wdata  (ram_wdata_c),
        .rdata  (rdata)
    );

    assign bus.m_data_in = rdata;
    assign bus.mem_ready = mem_ready_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;

endmodule
